// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions used by the stream_in and stream_out paths.
package axis_pkg;

    // Fixed sideband values; the accelerator uses a single stream id and destination.
    localparam logic AXIS_TID_DEFAULT   = 1'b0;
    localparam logic AXIS_TDEST_DEFAULT = 1'b0;

    // Frame-transfer state shared by both stream directions.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } axis_state_e;

endpackage

// File: rtl/stream_out_if.sv
// AXI-Stream bundle between stream_out (master) and the VDMA S2MM channel (slave).
interface stream_out_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tuser;
    logic                    tid;
    logic                    tdest;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        output tready
    );
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry registered valid/ready slice: a main register that drives the
// output and a skid register that catches the one beat in flight when the
// consumer stalls. Input ready is a flop, so it never depends on i_out_ready
// combinationally.
module axis_skid_buf #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_allow,   // upstream may send next cycle
    input  logic                 i_in_valid,   // qualified handshake (valid && o_in_ready)
    input  logic [PAYLOAD_W-1:0] i_in_data,
    output logic                 o_in_ready,
    output logic                 o_out_valid,
    output logic [PAYLOAD_W-1:0] o_out_data,
    input  logic                 i_out_ready
);

    logic                 r_main_valid;
    logic [PAYLOAD_W-1:0] r_main_data;
    logic                 r_skid_valid;
    logic [PAYLOAD_W-1:0] r_skid_data;
    logic                 r_in_ready;

    logic                 w_out_hs;
    logic                 w_main_valid_nx;
    logic [PAYLOAD_W-1:0] w_main_data_nx;
    logic                 w_skid_valid_nx;
    logic [PAYLOAD_W-1:0] w_skid_data_nx;

    assign w_out_hs = r_main_valid && i_out_ready;

    // Next contents of the two entries: skid refills main first, a new beat
    // goes to main when it is free or leaving, otherwise into skid.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        w_main_valid_nx = r_main_valid;
        w_main_data_nx  = r_main_data;
        w_skid_valid_nx = r_skid_valid;
        w_skid_data_nx  = r_skid_data;
        if (w_out_hs) begin
            if (r_skid_valid) begin
                w_main_data_nx  = r_skid_data;
                w_skid_valid_nx = 1'b0;
            end else if (i_in_valid) begin
                w_main_data_nx  = i_in_data;
            end else begin
                w_main_valid_nx = 1'b0;
            end
        end else if (i_in_valid) begin
            if (!r_main_valid) begin
                w_main_valid_nx = 1'b1;
                w_main_data_nx  = i_in_data;
            end else begin
                w_skid_valid_nx = 1'b1;
                w_skid_data_nx  = i_in_data;
            end
        end
    end

    // Register both entries and the ready flag; ready drops the cycle after skid fills.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: data registers are reset too, since the stream data must read zero after reset.
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_main_valid <= w_main_valid_nx;
            r_main_data  <= w_main_data_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_skid_data  <= w_skid_data_nx;
            r_in_ready   <= i_in_allow && !w_skid_valid_nx;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_main_valid;
    assign o_out_data  = r_main_data;

endmodule

// File: rtl/stream_out.sv
// Transmit side of the AXI-Stream path: takes upscaled pixels from Up-Sampling,
// tags SOF (tuser) and end-of-row (tlast) and forwards them to the VDMA through
// a registered skid buffer. One destination frame is sent per UPSTART.
module stream_out
    import axis_pkg::*;
#(
    parameter int AXISOUT_DATA_WIDTH = 32,
    parameter int UPSP_WRTDATA_WIDTH = 32,
    parameter int DST_IMG_WIDTH      = 3840,
    parameter int DST_IMG_HEIGHT     = 2160
) (
    input  logic                          m_axis_aclk,
    input  logic                          m_axis_arst,
    input  logic                          UPSTART,
    output logic                          FRAME_SENT,
    input  logic                          upsp_ac_wvalid,
    input  logic [UPSP_WRTDATA_WIDTH-1:0] upsp_ac_wdata,
    output logic                          ac_upsp_wready,
    stream_out_if.master                  m_axis
);

    localparam int COL_W = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
    localparam int ROW_W = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(DST_IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);

    // One buffered beat: pixel plus the sideband fixed at acceptance time.
    typedef struct packed {
        logic [AXISOUT_DATA_WIDTH-1:0] data;
        logic                          tuser;
        logic                          tlast;
        logic                          frame_end;
    } beat_t;

    axis_state_e      r_state;
    logic [COL_W-1:0] r_in_col;
    logic [ROW_W-1:0] r_in_row;

    beat_t w_in_beat;
    beat_t w_out_beat;
    logic  w_in_hs;
    logic  w_out_valid;
    logic  w_frame_done;
    logic  w_run_next;

    assign w_in_hs = upsp_ac_wvalid && ac_upsp_wready;

    assign w_in_beat.data      = upsp_ac_wdata;
    assign w_in_beat.tuser     = (r_in_row == '0) && (r_in_col == '0);
    assign w_in_beat.tlast     = (r_in_col == COL_LAST);
    assign w_in_beat.frame_end = w_in_beat.tlast && (r_in_row == ROW_LAST);

    // The frame-end beat leaving main while draining closes the frame.
    assign w_frame_done = (r_state == DRAIN) && w_out_valid && m_axis.tready
                          && w_out_beat.frame_end;

    // Whether the FSM will be in RUN next cycle; feeds the registered wready.
    assign w_run_next = ((r_state == IDLE) && UPSTART)
                     || ((r_state == RUN) && !(w_in_hs && w_in_beat.frame_end));

    // Frame FSM and input position counters.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_arst) begin
            r_state  <= IDLE;
            r_in_col <= '0;
            r_in_row <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (UPSTART) begin
                        r_state  <= RUN;
                        r_in_col <= '0;
                        r_in_row <= '0;
                    end
                end
                RUN: begin
                    if (w_in_hs) begin
                        if (w_in_beat.frame_end) begin
                            r_state <= DRAIN;
                        end
                        if (w_in_beat.tlast) begin
                            r_in_col <= '0;
                            r_in_row <= w_in_beat.frame_end ? '0 : r_in_row + ROW_W'(1);
                        end else begin
                            r_in_col <= r_in_col + COL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_frame_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    axis_skid_buf #(
        .PAYLOAD_W ($bits(beat_t))
    ) u_skid (
        .i_clk       (m_axis_aclk),
        .i_rst       (m_axis_arst),
        .i_in_allow  (w_run_next),
        .i_in_valid  (w_in_hs),
        .i_in_data   (w_in_beat),
        .o_in_ready  (ac_upsp_wready),
        .o_out_valid (w_out_valid),
        .o_out_data  (w_out_beat),
        .i_out_ready (m_axis.tready)
    );

    // FRAME_SENT must coincide with the VDMA handshake, so it is decoded from
    // the registered main entry and tready rather than registered itself.
    assign FRAME_SENT = w_frame_done && !m_axis_arst;

    assign m_axis.tvalid = w_out_valid;
    assign m_axis.tdata  = w_out_beat.data;
    assign m_axis.tuser  = w_out_beat.tuser;
    assign m_axis.tlast  = w_out_beat.tlast;
    assign m_axis.tstrb  = '1;
    assign m_axis.tkeep  = '1;
    assign m_axis.tid    = AXIS_TID_DEFAULT;
    assign m_axis.tdest  = AXIS_TDEST_DEFAULT;

endmodule

// File: tb/tb_stream_out.sv
// Self-checking bench for stream_out on a 4x3 frame: directed reset, framing,
// backpressure and gating scenarios plus randomized tready against a scoreboard.
module tb_stream_out;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          upstart = 1'b0;
    logic          frame_sent;
    logic          wvalid = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic          wready;

    stream_out_if #(.DATA_WIDTH(DW)) axis ();

    stream_out #(
        .AXISOUT_DATA_WIDTH (DW),
        .UPSP_WRTDATA_WIDTH (DW),
        .DST_IMG_WIDTH      (W),
        .DST_IMG_HEIGHT     (H)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_arst    (arst),
        .UPSTART        (upstart),
        .FRAME_SENT     (frame_sent),
        .upsp_ac_wvalid (wvalid),
        .upsp_ac_wdata  (wdata),
        .ac_upsp_wready (wready),
        .m_axis         (axis)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
        logic          f;
        int            c;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    bit   m_busy = 0;     // a frame has been started and not yet reported
    bit   m_accept = 0;   // model says the block may take input beats
    int   m_idx = 0;      // beats of the current frame accepted so far
    int   acc_cnt = 0;
    int   out_cnt = 0;
    int   fs_cnt = 0;
    int   max_lat = 0;
    int   gaps = 0;
    int   prev_out = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        exp_t e;
        bit   busy0;
        int   lat;
        if (arst) begin
            sb.delete();
            m_busy   = 0;
            m_accept = 0;
            m_idx    = 0;
        end else begin
            busy0 = m_busy;
            check("wready_gate", 32'(wready && !m_accept), 0);
            if (frame_sent) fs_cnt++;
            if (wvalid && wready) begin
                e.d = wdata;
                e.u = (m_idx == 0);
                e.l = ((m_idx % W) == W - 1);
                e.f = (m_idx == N - 1);
                e.c = cyc;
                sb.push_back(e);
                m_idx++;
                acc_cnt++;
                if (m_idx == N) m_accept = 0;
            end
            if (axis.tvalid && axis.tready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    check("tdata", axis.tdata, e.d);
                    check("tuser", 32'(axis.tuser), 32'(e.u));
                    check("tlast", 32'(axis.tlast), 32'(e.l));
                    check("frame_sent", 32'(frame_sent), 32'(e.f));
                    if (e.f) m_busy = 0;
                    lat = cyc - e.c;
                    if (lat > max_lat) max_lat = lat;
                    if (out_cnt > 0 && cyc != prev_out + 1) gaps++;
                    prev_out = cyc;
                    out_cnt++;
                end
            end else begin
                check("frame_sent_idle", 32'(frame_sent), 0);
            end
            if (upstart && !busy0) begin
                m_busy   = 1;
                m_accept = 1;
                m_idx    = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        int t = 0;
        bit done = 0;
        wvalid = 1'b1;
        wdata  = d;
        while (!done) begin
            @(negedge clk);
            if (wready) begin
                done = 1;
            end else if (++t > 300) begin
                check("send_wready", 32'(wready), 1);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        wvalid = 1'b0;
    endtask

    task automatic start_frame();
        upstart = 1'b1;
        tick(1);
        upstart = 1'b0;
    endtask

    task automatic wait_fs(input int target);
        int t = 0;
        while (fs_cnt < target && t < 3000) begin
            tick(1);
            t++;
        end
        if (fs_cnt < target) check("frame_sent_wait", 32'(fs_cnt), 32'(target));
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, "_tvalid"}, 32'(axis.tvalid), 0);
        check({tag, "_tuser"}, 32'(axis.tuser), 0);
        check({tag, "_tlast"}, 32'(axis.tlast), 0);
        check({tag, "_tdata"}, axis.tdata, 0);
        check({tag, "_wready"}, 32'(wready), 0);
        check({tag, "_frame_sent"}, 32'(frame_sent), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation timeout");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int base_fs;
        int base_acc;
        int base_out;
        int t;
        logic [DW-1:0] s_data;
        logic          s_user;
        logic          s_last;
        bit            rnd_on;

        axis.tready = 1'b1;

        // Reset held 2 cycles with wvalid asserted.
        tick(2);
        @(negedge clk);
        check_outputs_clear("rst");
        tick(1);
        arst = 1'b0;
        wvalid = 1'b0;

        // Idle gating: data offered before any UPSTART.
        wvalid = 1'b1;
        wdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_wready", 32'(wready), 0);
            check("idle_tvalid", 32'(axis.tvalid), 0);
            tick(1);
        end
        wvalid = 1'b0;

        // Full frame back-to-back with tready high.
        out_cnt = 0; gaps = 0; max_lat = 0;
        start_frame();
        for (int i = 0; i < N; i++) send(DW'(i));
        wait_fs(1);
        tick(2);
        check("f1_beats", 32'(out_cnt), N);
        check("f1_gaps", 32'(gaps), 0);
        check("f1_latency", 32'(max_lat), 1);
        check("f1_pulses", 32'(fs_cnt), 1);

        // 13th beat after FRAME_SENT must not be taken.
        wvalid = 1'b1;
        wdata  = 32'h0000_0055;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_wready", 32'(wready), 0);
            check("post_tvalid", 32'(axis.tvalid), 0);
            tick(1);
        end
        wvalid = 1'b0;

        // UPSTART held high through the whole RUN phase.
        base_fs  = fs_cnt;
        base_acc = acc_cnt;
        upstart  = 1'b1;
        tick(1);
        for (int i = 0; i < N; i++) send(32'h100 + DW'(i));
        upstart = 1'b0;
        wait_fs(base_fs + 1);
        tick(4);
        check("run_upstart_pulses", 32'(fs_cnt - base_fs), 1);
        check("run_upstart_beats", 32'(acc_cnt - base_acc), N);
        check("run_upstart_idle", 32'(axis.tvalid), 0);

        // Backpressure: tready low for 3 cycles mid-row.
        base_fs  = fs_cnt;
        base_out = out_cnt;
        fork
            begin
                start_frame();
                for (int i = 0; i < N; i++) send(32'h200 + DW'(i));
            end
            begin
                t = 0;
                while (out_cnt < base_out + 2 && t < 300) begin
                    tick(1);
                    t++;
                end
                axis.tready = 1'b0;
                base_acc = acc_cnt;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_tvalid", 32'(axis.tvalid), 1);
                    if (k == 0) begin
                        s_data = axis.tdata;
                        s_user = axis.tuser;
                        s_last = axis.tlast;
                    end else begin
                        check("stall_tdata", axis.tdata, s_data);
                        check("stall_tuser", 32'(axis.tuser), 32'(s_user));
                        check("stall_tlast", 32'(axis.tlast), 32'(s_last));
                    end
                    if (k == 2) check("stall_wready", 32'(wready), 0);
                end
                tick(1);
                check("stall_extra_beats", 32'(acc_cnt - base_acc), 1);
                axis.tready = 1'b1;
            end
        join
        wait_fs(base_fs + 1);
        tick(2);

        // Reset mid-frame after beat 5 with beats still buffered.
        start_frame();
        for (int i = 0; i < 4; i++) send(32'h300 + DW'(i));
        axis.tready = 1'b0;
        send(32'h304);
        @(negedge clk);
        check("pre_rst_tvalid", 32'(axis.tvalid), 1);
        tick(1);
        arst = 1'b1;
        tick(1);
        @(negedge clk);
        check_outputs_clear("midrst");
        tick(1);
        arst = 1'b0;
        axis.tready = 1'b1;
        base_fs = fs_cnt;
        start_frame();
        for (int i = 0; i < N; i++) send(32'h400 + DW'(i));
        wait_fs(base_fs + 1);
        tick(2);

        // Random tready and input gaps over 3 frames.
        base_fs = fs_cnt;
        rnd_on  = 1;
        fork
            begin
                while (rnd_on) begin
                    axis.tready = ($urandom % 4) != 0;
                    tick(1);
                end
                axis.tready = 1'b1;
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    start_frame();
                    for (int i = 0; i < N; i++) begin
                        tick($urandom_range(0, 2));
                        send($urandom);
                    end
                    wait_fs(base_fs + f + 1);
                end
                rnd_on = 0;
            end
        join
        tick(5);
        check("rand_pulses", 32'(fs_cnt - base_fs), 3);
        check("sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
